// File: rtl/btb_pkg.sv
// Shared constants, flush FSM states and helpers for the set-associative BTB.
package btb_pkg;

  localparam logic [1:0] CNT_SNT = 2'd0;
  localparam logic [1:0] CNT_WNT = 2'd1;
  localparam logic [1:0] CNT_WT  = 2'd2;
  localparam logic [1:0] CNT_ST  = 2'd3;

  typedef enum logic {
    IDLE  = 1'b0,
    FLUSH = 1'b1
  } flush_state_e;

  function automatic int clog2(input int v);
    int r;
    r = 0;
    for (int i = 0; i < 31; i++) if ((1 << i) < v) r = i + 1;
    return r;
  endfunction

endpackage

// File: rtl/btb_sat_counter.sv
// 2-bit saturating direction counter; load takes priority over inc/dec.
module btb_sat_counter
  import btb_pkg::*;
(
  input  logic       clk,
  input  logic       rst_n,
  input  logic       inc_i,
  input  logic       dec_i,
  input  logic       load_i,
  input  logic [1:0] load_val_i,
  output logic [1:0] cnt_o
);

  logic [1:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (load_i)                        cnt_d = load_val_i;
    else if (inc_i && cnt_q != CNT_ST)  cnt_d = cnt_q + 2'd1;
    else if (dec_i && cnt_q != CNT_SNT) cnt_d = cnt_q - 2'd1;
  end

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) cnt_q <= CNT_SNT;
    else        cnt_q <= cnt_d;

  assign cnt_o = cnt_q;

endmodule

// File: rtl/branch_target_assoc.sv
// Set-associative BTB: combinational lookup, clocked EX update, round-robin eviction, sequenced flush.
// Define BTB_COUNTER_EN to add per-entry 2-bit direction counters; otherwise every hit predicts taken.
module branch_target_assoc
  import btb_pkg::*;
#(
  parameter int WIDTH_DATA_LENGTH = 32,
  parameter int WIDTH_ENTRY_LENTH = 3,
  parameter int WAYS              = 2
) (
  input  logic                         clk,
  input  logic                         rst_n,
  input  logic [WIDTH_DATA_LENGTH-1:0] PC,
  input  logic [WIDTH_DATA_LENGTH-1:0] PC_Ex,
  input  logic [WIDTH_DATA_LENGTH-1:0] PC_ALU,
  input  logic                         Br_Resolved,
  input  logic                         Br_Taken,
  input  logic                         Flush,
  output logic                         Hit,
  output logic                         Predict_Taken,
  output logic [WIDTH_DATA_LENGTH-1:0] Target_Add,
  output logic                         Busy
);

  localparam int SETS  = 1 << WIDTH_ENTRY_LENTH;
  localparam int TAG_W = WIDTH_DATA_LENGTH - 2 - WIDTH_ENTRY_LENTH;
  localparam int PTR_W = clog2(WAYS);

  logic [WIDTH_ENTRY_LENTH-1:0] idx, ex_idx;
  logic [TAG_W-1:0]             tag, ex_tag;
  logic                         unused_lsb;

  assign idx        = PC[WIDTH_ENTRY_LENTH+1:2];
  assign tag        = PC[WIDTH_DATA_LENGTH-1:WIDTH_ENTRY_LENTH+2];
  assign ex_idx     = PC_Ex[WIDTH_ENTRY_LENTH+1:2];
  assign ex_tag     = PC_Ex[WIDTH_DATA_LENGTH-1:WIDTH_ENTRY_LENTH+2];
  assign unused_lsb = ^{PC[1:0], PC_Ex[1:0]};

  logic [SETS-1:0][WAYS-1:0]    valid_q;
  logic [SETS-1:0][PTR_W-1:0]   rr_q;
  logic [TAG_W-1:0]             tag_q [SETS][WAYS];
  logic [WIDTH_DATA_LENGTH-1:0] tgt_q [SETS][WAYS];

  flush_state_e                 state_q, state_d;
  logic [WIDTH_ENTRY_LENTH-1:0] fcnt_q, fcnt_d;
  logic                         busy;

  // Flush FSM: state register / next state / outputs
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state_q <= IDLE;
      fcnt_q  <= '0;
    end else begin
      state_q <= state_d;
      fcnt_q  <= fcnt_d;
    end

  always_comb begin
    state_d = state_q;
    fcnt_d  = fcnt_q;
    case (state_q)
      IDLE:  if (Flush) begin state_d = FLUSH; fcnt_d = '0; end
      FLUSH: begin
        if (Flush)        fcnt_d  = '0;
        else if (&fcnt_q) state_d = IDLE;
        else              fcnt_d  = fcnt_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb busy = (state_q == FLUSH);
  assign Busy = busy;

`ifdef BTB_COUNTER_EN
  logic [SETS-1:0][WAYS-1:0][1:0] cnt;
`endif

  logic                         hit_m, pt_m;
  logic [WIDTH_DATA_LENGTH-1:0] tgt_m;

  // Update logic keeps at most one matching way, so OR-combining is a clean mux.
  always_comb begin
    hit_m = 1'b0;
    pt_m  = 1'b0;
    tgt_m = '0;
    for (int w = 0; w < WAYS; w++)
      if (valid_q[idx][w] && tag_q[idx][w] == tag) begin
        hit_m = 1'b1;
        tgt_m = tgt_m | tgt_q[idx][w];
`ifdef BTB_COUNTER_EN
        pt_m  = pt_m | cnt[idx][w][1];
`else
        pt_m  = 1'b1;
`endif
      end
  end

  assign Hit           = hit_m & ~busy;
  assign Predict_Taken = pt_m & Hit;
  assign Target_Add    = busy ? '0 : tgt_m;

  logic [WAYS-1:0]  ex_match;
  logic             ex_hit, all_valid, upd_en, wr_tkn, alloc;
  logic [PTR_W-1:0] ex_way, inv_way, alloc_way, wr_way;

  always_comb begin
    ex_match = '0;
    ex_way   = '0;
    inv_way  = '0;
    for (int w = WAYS - 1; w >= 0; w--) begin
      ex_match[w] = valid_q[ex_idx][w] && tag_q[ex_idx][w] == ex_tag;
      if (ex_match[w])         ex_way  = PTR_W'(w);
      if (!valid_q[ex_idx][w]) inv_way = PTR_W'(w);
    end
  end

  assign ex_hit    = |ex_match;
  assign all_valid = &valid_q[ex_idx];
  assign alloc_way = all_valid ? rr_q[ex_idx] : inv_way;
  assign upd_en    = Br_Resolved & ~busy;
  assign wr_tkn    = upd_en & Br_Taken;
  assign alloc     = wr_tkn & ~ex_hit;
  assign wr_way    = ex_hit ? ex_way : alloc_way;

  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      valid_q <= '0;
      rr_q    <= '0;
    end else if (busy) begin
      valid_q[fcnt_q] <= '0;
      rr_q[fcnt_q]    <= '0;
    end else if (alloc) begin
      valid_q[ex_idx][alloc_way] <= 1'b1;
      if (all_valid) rr_q[ex_idx] <= rr_q[ex_idx] + 1'b1;
    end

  // Tag and target payload is not reset; valid bits gate it.
  always_ff @(posedge clk) begin
    if (alloc)  tag_q[ex_idx][alloc_way] <= ex_tag;
    if (wr_tkn) tgt_q[ex_idx][wr_way]    <= PC_ALU;
  end

`ifdef BTB_COUNTER_EN
  for (genvar s = 0; s < SETS; s++) begin : g_set
    logic set_sel;
    assign set_sel = (ex_idx == WIDTH_ENTRY_LENTH'(s));
    for (genvar w = 0; w < WAYS; w++) begin : g_way
      btb_sat_counter u_cnt (
        .clk        (clk),
        .rst_n      (rst_n),
        .inc_i      (wr_tkn & set_sel & ex_match[w]),
        .dec_i      (upd_en & ~Br_Taken & set_sel & ex_match[w]),
        .load_i     (alloc & set_sel & (alloc_way == PTR_W'(w))),
        .load_val_i (CNT_WT),
        .cnt_o      (cnt[s][w])
      );
    end
  end
`endif

endmodule

// File: tb/tb_branch_target_assoc.sv
// Randomised and directed bench for branch_target_assoc against a behavioural table model.
module tb_branch_target_assoc;

  localparam int SETS = 8;
  localparam int WAYS = 2;
  localparam int TW   = 27;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] PC = '0, PC_Ex = '0, PC_ALU = '0;
  logic        Br_Resolved = 1'b0, Br_Taken = 1'b0, Flush = 1'b0;
  logic        Hit, Predict_Taken, Busy;
  logic [31:0] Target_Add;

  branch_target_assoc dut (
    .clk(clk), .rst_n(rst_n), .PC(PC), .PC_Ex(PC_Ex), .PC_ALU(PC_ALU),
    .Br_Resolved(Br_Resolved), .Br_Taken(Br_Taken), .Flush(Flush),
    .Hit(Hit), .Predict_Taken(Predict_Taken), .Target_Add(Target_Add), .Busy(Busy)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0;

  bit          m_v   [SETS][WAYS];
  logic [TW-1:0] m_tag [SETS][WAYS];
  logic [31:0] m_tgt [SETS][WAYS];
  int          m_cnt [SETS][WAYS];
  int          m_rr  [SETS];
  bit          m_busy;
  int          m_fpos;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int s = 0; s < SETS; s++) begin
      m_rr[s] = 0;
      for (int w = 0; w < WAYS; w++) begin m_v[s][w] = 0; m_cnt[s][w] = 0; end
    end
    m_busy = 0;
    m_fpos = 0;
  endtask

  task automatic m_look(input logic [31:0] pc, output bit h, output bit pt, output logic [31:0] t);
    int s;
    s = int'(pc[4:2]);
    h = 0; pt = 0; t = '0;
    if (!m_busy)
      for (int w = 0; w < WAYS; w++)
        if (m_v[s][w] && m_tag[s][w] == pc[31:5]) begin
          h = 1;
          t = m_tgt[s][w];
`ifdef BTB_COUNTER_EN
          pt = (m_cnt[s][w] >= 2);
`else
          pt = 1;
`endif
        end
  endtask

  task automatic m_step();
    int s, hw, aw;
    if (m_busy) begin
      for (int w = 0; w < WAYS; w++) m_v[m_fpos][w] = 0;
      m_rr[m_fpos] = 0;
      if (Flush)                 m_fpos = 0;
      else if (m_fpos == SETS-1) m_busy = 0;
      else                       m_fpos++;
    end else begin
      if (Br_Resolved) begin
        s = int'(PC_Ex[4:2]);
        hw = -1;
        for (int w = 0; w < WAYS; w++) if (m_v[s][w] && m_tag[s][w] == PC_Ex[31:5]) hw = w;
        if (hw >= 0) begin
          if (Br_Taken) begin
            m_cnt[s][hw] = (m_cnt[s][hw] < 3) ? m_cnt[s][hw] + 1 : 3;
            m_tgt[s][hw] = PC_ALU;
          end else m_cnt[s][hw] = (m_cnt[s][hw] > 0) ? m_cnt[s][hw] - 1 : 0;
        end else if (Br_Taken) begin
          aw = -1;
          for (int w = 0; w < WAYS; w++) if (!m_v[s][w] && aw < 0) aw = w;
          if (aw < 0) begin aw = m_rr[s]; m_rr[s] = (m_rr[s] + 1) % WAYS; end
          m_v[s][aw] = 1; m_tag[s][aw] = PC_Ex[31:5];
          m_tgt[s][aw] = PC_ALU; m_cnt[s][aw] = 2;
        end
      end
      if (Flush) begin m_busy = 1; m_fpos = 0; end
    end
  endtask

  task automatic drive(input logic [31:0] pc, pcex, alu, input bit res, tkn, fl);
    bit eh, ep;
    logic [31:0] et;
    PC = pc; PC_Ex = pcex; PC_ALU = alu;
    Br_Resolved = res; Br_Taken = tkn; Flush = fl;
    #1;
    m_look(pc, eh, ep, et);
    chk("hit", 32'(Hit), 32'(eh));
    chk("predict_taken", 32'(Predict_Taken), 32'(ep));
    chk("target", Target_Add, et);
    chk("busy", 32'(Busy), 32'(m_busy));
  endtask

  task automatic tick();
    @(posedge clk);
    if (rst_n) m_step();
    @(negedge clk);
  endtask

  task automatic look(input logic [31:0] pc);
    drive(pc, '0, '0, 0, 0, 0);
  endtask

  task automatic br(input logic [31:0] pcex, alu, input bit tkn);
    drive('0, pcex, alu, 1, tkn, 0);
    tick();
  endtask

  int busy_cycles;

  initial begin
    #1;
    chk("reset_hit", 32'(Hit), 0);
    chk("reset_busy", 32'(Busy), 0);
    chk("reset_target", Target_Add, 0);
    m_reset();
    @(negedge clk);
    rst_n = 1'b1;

    look(32'h100);
    chk("empty_hit", 32'(Hit), 0);
    chk("empty_target", Target_Add, 0);
    tick();

    br(32'h100, 32'h200, 1);
    look(32'h100);
    chk("alloc_hit", 32'(Hit), 1);
    chk("alloc_pt", 32'(Predict_Taken), 1);
    chk("alloc_target", Target_Add, 32'h200);
    tick();

    br(32'h120, 32'h220, 1);
    br(32'h140, 32'h240, 1);
    look(32'h100); chk("evicted_hit", 32'(Hit), 0); tick();
    look(32'h120); chk("way1_hit", 32'(Hit), 1); chk("way1_target", Target_Add, 32'h220); tick();
    look(32'h140); chk("way0_hit", 32'(Hit), 1); chk("way0_target", Target_Add, 32'h240); tick();

    br(32'h140, 32'h0, 0);
    br(32'h140, 32'h0, 0);
    look(32'h140);
    chk("nt_hit", 32'(Hit), 1);
`ifdef BTB_COUNTER_EN
    chk("nt_pt", 32'(Predict_Taken), 0);
`else
    chk("nt_pt", 32'(Predict_Taken), 1);
`endif
    chk("nt_target", Target_Add, 32'h240);
    tick();
    for (int i = 0; i < 4; i++) br(32'h140, 32'h340, 1);
    br(32'h140, 32'h0, 0);
    look(32'h140);
    chk("sat_pt", 32'(Predict_Taken), 1);
    chk("sat_target", Target_Add, 32'h340);
    tick();

    for (int s = 0; s < SETS; s++) br(32'h1000 + 32'(s*4), 32'h5000 + 32'(s*4), 1);
    drive('0, '0, '0, 0, 0, 1);
    tick();
    busy_cycles = 0;
    for (int i = 0; i < 20; i++) begin
      drive(32'h1000 + 32'((i % 8) * 4), 32'h2000, 32'h6000, i < 8, 1, 0);
      if (Busy) begin
        busy_cycles++;
        chk("flush_hit_forced", 32'(Hit), 0);
      end
      tick();
    end
    chk("flush_busy_cycles", 32'(busy_cycles), 8);
    look(32'h2000); chk("dropped_update", 32'(Hit), 0); tick();
    for (int s = 0; s < SETS; s++) begin
      look(32'h1000 + 32'(s*4)); chk("flushed_miss", 32'(Hit), 0); tick();
    end
    look(32'h140); chk("flushed_miss_140", 32'(Hit), 0); tick();

    br(32'h101C, 32'h7000, 1);
    drive('0, '0, '0, 0, 0, 1);
    tick();
    for (int i = 0; i < 3; i++) begin look(32'h101C); tick(); end
    rst_n = 1'b0;
    #1;
    m_reset();
    chk("midflush_rst_busy", 32'(Busy), 0);
    chk("midflush_rst_hit", 32'(Hit), 0);
    chk("midflush_rst_target", Target_Add, 0);
    @(negedge clk);
    rst_n = 1'b1;
    look(32'h101C); chk("post_rst_miss", 32'(Hit), 0); tick();
    br(32'h101C, 32'h7100, 1);
    look(32'h101C);
    chk("post_rst_hit", 32'(Hit), 1);
    chk("post_rst_target", Target_Add, 32'h7100);
    tick();

    for (int i = 0; i < 3000; i++) begin
      drive((32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
            (32'($urandom_range(0, 3)) << 5) | (32'($urandom_range(0, 7)) << 2) | 32'($urandom_range(0, 3)),
            $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), $urandom_range(0, 99) == 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/branch_target_assoc.md
# branch_target_assoc

Parametrised set-associative branch target buffer with valid bits, per-entry 2-bit direction counters, round-robin replacement and a sequenced flush. It sits in the IF stage: the fetch PC is looked up combinationally each cycle, and resolved branches from EX update the table on the clock edge. It is the next-generation replacement for the direct-mapped, always-taken 8-entry BTB.

## Interface
- WIDTH_DATA_LENGTH, 32: PC and target width.
- WIDTH_ENTRY_LENTH, 3: set index bits; SETS = 1<<WIDTH_ENTRY_LENTH.
- WAYS, 2: associativity; power of two, ≥2.
- Tag width is derived, not a parameter: TAG_W = WIDTH_DATA_LENGTH-2-WIDTH_ENTRY_LENTH.
- clk  in  1  clock; all state updates on the rising edge.
- rst_n  in  1  reset; asynchronous, active-low.
- PC  in  WIDTH_DATA_LENGTH  fetch PC to look up.
- PC_Ex  in  WIDTH_DATA_LENGTH  PC of the resolved branch in EX.
- PC_ALU  in  WIDTH_DATA_LENGTH  computed branch target.
- Br_Resolved  in  1  branch in EX resolved this cycle.
- Br_Taken  in  1  outcome of the resolved branch; qualified by Br_Resolved.
- Flush  in  1  single-cycle request to invalidate the whole table.
- Hit  out  1  valid tag match for PC.
- Predict_Taken  out  1  Hit and counter MSB set.
- Target_Add  out  WIDTH_DATA_LENGTH  stored target of the hitting way; 0 on miss.
- Busy  out  1  flush in progress.

## Operation
- Index = PC[WIDTH_ENTRY_LENTH+1:2]; tag = PC[WIDTH_DATA_LENGTH-1:WIDTH_ENTRY_LENTH+2]. The same split applies to PC_Ex.
- Lookup (combinational): compare all ways of the indexed set against the tag, qualified by valid. At most one way matches, which the update rules guarantee. If no way matches: Hit=0, Predict_Taken=0, Target_Add=0.
- Update when Br_Resolved=1 and the block is not Busy:
  - Hit in a way, taken: counter increments, saturating at 3; target is overwritten with PC_ALU.
  - Hit in a way, not taken: counter decrements, saturating at 0; target is unchanged.
  - Miss, taken: allocate into the lowest-index invalid way. If every way is valid, allocate into the way given by the set's round-robin pointer and advance the pointer modulo WAYS. The allocated entry gets tag, target=PC_ALU, valid=1, counter=2 (weakly taken).
  - Miss, not taken: no change.
- Flush state machine:
  - States: IDLE and FLUSH.
  - IDLE→FLUSH on Flush=1; the set counter loads 0.
  - In FLUSH, one set is invalidated per cycle; its round-robin pointer also clears to 0.
  - FLUSH→IDLE after set SETS-1 is cleared.
  - Flush=1 while in FLUSH restarts the counter at 0.
- While Busy=1: Hit=0, Predict_Taken=0, Target_Add=0, and Br_Resolved is ignored (the update is dropped).

## Timing
- Lookup has zero latency: outputs follow PC in the same cycle.
- Update has one-cycle latency: a write takes effect at the posedge and is visible to lookups from the next cycle.
- Same-cycle lookup and update of the same set: the lookup sees pre-update contents.
- Flush occupies exactly SETS cycles with Busy=1, starting the cycle after Flush is sampled. Busy falls the cycle after set SETS-1 is cleared.
- Reset (async, any time, including mid-flush):
  - All valid bits=0, round-robin pointers=0, counters=0, state=IDLE, Busy=0.
  - Outputs immediately: Hit=0, Predict_Taken=0, Target_Add=0.
  - Tag and target arrays are not reset.
- After a taken hit, the counter at 3 stays at 3. After a not-taken hit, the counter at 0 stays at 0.

## Configuration
- BTB_COUNTER_EN defined: 2-bit counters are instantiated, and Predict_Taken = Hit & counter[1].
- BTB_COUNTER_EN undefined: no counter storage. Predict_Taken = Hit, i.e. every hit is predicted taken. A not-taken hit leaves the entry unchanged. Allocation is otherwise identical.

## Structure
- btb_pkg holds:
  - Counter constants: CNT_SNT=0, CNT_WNT=1, CNT_WT=2, CNT_ST=3.
  - The flush state enum (IDLE, FLUSH).
  - A clog2 function used for the pointer width.
- One natural sub-module, btb_sat_counter: 2-bit saturating counter with increment/decrement inputs. It is instantiated per way and per set when BTB_COUNTER_EN is defined.

## Test plan
- Reset, then look up PC=0x100 → Hit=0, Target_Add=0, Busy=0.
- Resolve taken PC_Ex=0x100 with PC_ALU=0x200; next cycle PC=0x100 → Hit=1, Predict_Taken=1, Target_Add=0x200.
- Default params, taken branches at 0x100, 0x120, 0x140 (same set 0, different tags) → 0x100 and 0x120 fill ways 0/1. 0x140 evicts way 0 (pointer=0) and the pointer becomes 1. Lookup of 0x100 → Hit=0; 0x120 and 0x140 → Hit=1.
- With BTB_COUNTER_EN: entry at 0x100, two not-taken resolutions → counter 2→1→0, Hit=1, Predict_Taken=0. Three taken resolutions → counter reaches 3 and stays at 3.
- Flush with 8 sets populated → Busy=1 for exactly 8 cycles, Hit forced 0, and a Br_Resolved during this window is dropped. After Busy falls, every prior PC misses.
- Assert rst_n low at flush cycle 3 → Busy=0 and all entries invalid immediately; after release, the table accepts allocation normally.
